// File: rtl/int_div_recon.sv
// Rebuilds a 64-bit dividend from quotient, divisor and remainder: quo*div + mod (unsigned).
// Radix-2 shift-add multiply over W cycles, then one cycle to add the remainder.
module int_div_recon #(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   quo,
  input  logic [W-1:0]   div,
  input  logic [W-1:0]   mod,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] dividend,
  output logic           mod_ok,
  output logic           div_zero
);

  typedef enum logic [1:0] {StIdle, StMul, StAdd, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     div_q;
  logic [W-1:0]     mod_q;
  logic [2*W-1:0]   prod_q;
  logic [2*W-1:0]   prod_next;
  logic [W:0]       sum;

  // Upper half accumulates the divisor with a carry bit; the whole product shifts right each step.
  always_comb begin
    sum       = {1'b0, prod_q[2*W-1:W]} + {1'b0, div_q};
    prod_next = prod_q[0] ? {sum, prod_q[W-1:1]} : (prod_q >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      div_q    <= '0;
      mod_q    <= '0;
      prod_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dividend <= '0;
      mod_ok   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            div_q    <= div;
            mod_q    <= mod;
            prod_q   <= {{W{1'b0}}, quo};
            cnt_q    <= '0;
            mod_ok   <= (mod < div);
            div_zero <= (div == '0);
            busy     <= 1'b1;
            state_q  <= StMul;
          end
        end
        StMul: begin
          prod_q <= prod_next;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(W - 1)) begin
            state_q <= StAdd;
          end
        end
        StAdd: begin
          dividend <= prod_q + {{W{1'b0}}, mod_q};
          done     <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StDone;
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
